// File: rtl/simon_pkg.sv
// Shared Simon Says definitions: direction codes, key-to-direction mapping
// and the state encoding used by the input checker.
package simon_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_PRESS = 2'd1;
  localparam state_t ST_VERDICT    = 2'd2;

  // Key vector bit order is up, right, down, left; only meaningful for one-hot input.
  function automatic logic [1:0] key_to_dir(input logic [3:0] keys);
    logic [1:0] dir;
    dir = DIR_UP;
    case (keys)
      4'b0001: dir = DIR_UP;
      4'b0010: dir = DIR_RIGHT;
      4'b0100: dir = DIR_DOWN;
      4'b1000: dir = DIR_LEFT;
      default: dir = DIR_UP;
    endcase
    return dir;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single push-button conditioner: 2-flop synchronizer, inversion of the
// active-low level, then a stability counter that only lets a new level
// through after it has held for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n_i,
  output logic pressed_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // Bring the asynchronous button into the clock domain; idle level is released (1).
  always_ff @(posedge clock) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], key_n_i};
  end

  assign level = ~sync_q[1];

  // Count consecutive cycles the synced level disagrees with the output; any return resets.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (level != out_q) begin
      if (cnt_q == CNT_LAST) out_d = level;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign pressed_o = out_q;

endmodule

// File: rtl/player_input_checker.sv
// Player side of a Simon Says round: debounces the four arrow buttons,
// qualifies clean single-key presses, compares them with the latched
// sequence and reports pass / fail (wrong key or per-step timeout).
module player_input_checker
  import simon_pkg::*;
#(
  parameter int STEPS           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000,
  localparam int SW             = $clog2(STEPS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [2*STEPS-1:0] sequence_i,
  input  logic [3:0]         key_n_i,
  output logic               busy_o,
  output logic               echo_valid_o,
  output logic [1:0]         echo_dir_o,
  output logic [SW-1:0]      step_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic               fail_timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STEPS_DONE = SW'(STEPS);

  logic [3:0]         deb;
  logic [3:0]         deb_prev_q;
  logic               armed_q, armed_d;
  state_t             state_q, state_d;
  logic [2*STEPS-1:0] seq_q, seq_d;
  logic [SW-1:0]      step_q, step_d;
  logic [SW-1:0]      step_nxt;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               echo_valid_q, echo_valid_d;
  logic [1:0]         echo_dir_q, echo_dir_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               ftmo_q, ftmo_d;
  logic               press_evt;
  logic [1:0]         press_dir;
  logic [1:0]         exp_dir;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock     (clock),
      .reset_n   (reset_n),
      .key_n_i   (key_n_i[g]),
      .pressed_o (deb[g])
    );
  end

  // A press only counts when coming straight out of all-released into exactly one key.
  assign press_evt = armed_q && (deb_prev_q == 4'b0000) && is_onehot4(deb);
  assign press_dir = key_to_dir(deb);
  assign step_nxt  = step_q + SW'(1);

  // Select the direction expected at the current step.
  always_comb begin
    exp_dir = DIR_UP;
    for (int k = 0; k < STEPS; k++) begin
      if (step_q == SW'(k)) exp_dir = seq_q[2*k +: 2];
    end
  end

  // Round control: start latching, press checking, timeout and verdict.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    step_d       = step_q;
    tmo_d        = tmo_q;
    ftmo_d       = ftmo_q;
    echo_dir_d   = echo_dir_q;
    echo_valid_d = 1'b0;
    pass_d       = 1'b0;
    fail_d       = 1'b0;
    armed_d      = armed_q | (deb == 4'b0000);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          seq_d   = sequence_i;
          step_d  = '0;
          tmo_d   = '0;
          ftmo_d  = 1'b0;
          armed_d = (deb == 4'b0000);
          state_d = ST_WAIT_PRESS;
        end
      end
      ST_WAIT_PRESS: begin
        if (press_evt) begin
          armed_d      = 1'b0;
          echo_valid_d = 1'b1;
          echo_dir_d   = press_dir;
          if (press_dir == exp_dir) begin
            step_d = step_nxt;
            tmo_d  = '0;
            if (step_nxt == STEPS_DONE) begin
              pass_d  = 1'b1;
              state_d = ST_VERDICT;
            end
          end else begin
            fail_d  = 1'b1;
            ftmo_d  = 1'b0;
            state_d = ST_VERDICT;
          end
        end else if (tmo_q == TMO_LAST) begin
          fail_d  = 1'b1;
          ftmo_d  = 1'b1;
          state_d = ST_VERDICT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_VERDICT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any round in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      seq_q        <= '0;
      step_q       <= '0;
      tmo_q        <= '0;
      ftmo_q       <= 1'b0;
      echo_dir_q   <= DIR_UP;
      echo_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      armed_q      <= 1'b0;
      deb_prev_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      step_q       <= step_d;
      tmo_q        <= tmo_d;
      ftmo_q       <= ftmo_d;
      echo_dir_q   <= echo_dir_d;
      echo_valid_q <= echo_valid_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      armed_q      <= armed_d;
      deb_prev_q   <= deb;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign echo_valid_o   = echo_valid_q;
  assign echo_dir_o     = echo_dir_q;
  assign step_o         = step_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign fail_timeout_o = ftmo_q;

endmodule

// File: tb/tb_player_input_checker.sv
// Directed bench for player_input_checker with an echo scoreboard.
module tb_player_input_checker;

  localparam int STEPS = 4;
  localparam int DEB   = 4;
  localparam int TMO   = 100;
  localparam int SW    = $clog2(STEPS + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic [7:0]    sequence_i;
  logic [3:0]    key_n_i;
  logic          busy_o, echo_valid_o, pass_o, fail_o, fail_timeout_o;
  logic [1:0]    echo_dir_o;
  logic [SW-1:0] step_o;

  typedef struct {
    logic [1:0] dir;
    logic [2:0] step;
    logic       pass;
    logic       fail;
    logic       ftmo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   echo_cnt = 0;
  logic chk_busy_q = 1'b0;

  always #5 clock = ~clock;

  player_input_checker #(
    .STEPS(STEPS), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_i(start_i), .sequence_i(sequence_i),
    .key_n_i(key_n_i), .busy_o(busy_o), .echo_valid_o(echo_valid_o),
    .echo_dir_o(echo_dir_o), .step_o(step_o), .pass_o(pass_o), .fail_o(fail_o),
    .fail_timeout_o(fail_timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_echo(input logic [1:0] dir, input logic [2:0] stp,
                             input logic ps, input logic fl, input logic ft);
    exp_t x;
    x.dir = dir; x.step = stp; x.pass = ps; x.fail = fl; x.ftmo = ft;
    sb.push_back(x);
  endtask

  task automatic press(input int idx);
    key_n_i[idx] = 1'b0;
    tick(10);
    key_n_i = 4'hF;
    tick(10);
  endtask

  task automatic start_round(input logic [7:0] seq);
    sequence_i = seq;
    start_i    = 1'b1;
    tick(1);
    start_i    = 1'b0;
  endtask

  task automatic wait_fail(input int limit, output int n);
    n = 0;
    while (fail_o !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, busy_o, 0);
    check({pfx, "_echo_valid"}, echo_valid_o, 0);
    check({pfx, "_echo_dir"}, echo_dir_o, 0);
    check({pfx, "_step"}, step_o, 0);
    check({pfx, "_pass"}, pass_o, 0);
    check({pfx, "_fail"}, fail_o, 0);
    check({pfx, "_fail_timeout"}, fail_timeout_o, 0);
  endtask

  // Scoreboard monitor: every echo pops one expectation; busy must drop after a verdict.
  always @(negedge clock) begin
    if (chk_busy_q) check("busy_after_verdict", busy_o, 0);
    chk_busy_q <= reset_n & (pass_o | fail_o);
    if (echo_valid_o === 1'b1) begin
      echo_cnt++;
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_echo: observed dir %0h with empty queue, required no echo", echo_dir_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("echo_dir", echo_dir_o, e.dir);
        check("echo_step", step_o, e.step);
        check("echo_pass", pass_o, e.pass);
        check("echo_fail", fail_o, e.fail);
        if (e.fail) check("echo_fail_timeout", fail_timeout_o, e.ftmo);
      end
    end
  end

  initial begin
    int n;
    int e0;
    key_n_i    = 4'hF;
    start_i    = 1'b0;
    sequence_i = 8'h00;
    reset_n    = 1'b0;
    tick(3);
    check_reset_values("reset");
    reset_n = 1'b1;
    tick(2);

    // Round 1: full correct sequence
    start_round(8'b11_10_01_00);
    check("r1_busy_after_start", busy_o, 1);
    check("r1_step_after_start", step_o, 0);
    expect_echo(2'b00, 3'd1, 1'b0, 1'b0, 1'b0);
    expect_echo(2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    expect_echo(2'b10, 3'd3, 1'b0, 1'b0, 1'b0);
    expect_echo(2'b11, 3'd4, 1'b1, 1'b0, 1'b0);
    press(0); press(1); press(2); press(3);
    check("r1_sb_drained", sb.size(), 0);
    check("r1_busy_end", busy_o, 0);
    check("r1_step_end", step_o, 4);

    // Round 2: wrong second key
    start_round(8'b11_10_01_00);
    expect_echo(2'b00, 3'd1, 1'b0, 1'b0, 1'b0);
    press(0);
    expect_echo(2'b10, 3'd1, 1'b0, 1'b1, 1'b0);
    press(2);
    check("r2_sb_drained", sb.size(), 0);
    check("r2_fail_timeout_held", fail_timeout_o, 0);

    // Round 3: no presses, timeout
    e0 = echo_cnt;
    start_round(8'b11_10_01_00);
    wait_fail(150, n);
    check("r3_timeout_latency", n, TMO);
    check("r3_fail_timeout", fail_timeout_o, 1);
    check("r3_no_echo_at_verdict", echo_valid_o, 0);
    tick(1);
    check("r3_fail_timeout_holds", fail_timeout_o, 1);
    check("r3_no_echo_count", echo_cnt - e0, 0);

    // Round 4: bounce, multi-key, mid-round start
    start_round(8'b11_10_01_00);
    check("r4_fail_timeout_cleared", fail_timeout_o, 0);
    e0 = echo_cnt;
    expect_echo(2'b00, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      key_n_i[0] = 1'b0; tick(2);
      key_n_i[0] = 1'b1; tick(2);
    end
    key_n_i[0] = 1'b0; tick(10);
    key_n_i = 4'hF; tick(10);
    check("r4_bounce_one_echo", echo_cnt - e0, 1);
    check("r4_bounce_sb_drained", sb.size(), 0);
    e0 = echo_cnt;
    key_n_i = 4'b1100; tick(10);
    key_n_i = 4'hF; tick(10);
    check("r4_multikey_no_echo", echo_cnt - e0, 0);
    check("r4_multikey_step", step_o, 1);
    expect_echo(2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    press(1);
    start_round(8'h00);
    check("r4_midstart_step", step_o, 2);
    check("r4_midstart_busy", busy_o, 1);
    expect_echo(2'b10, 3'd3, 1'b0, 1'b0, 1'b0);
    press(2);
    check("r4_sb_drained", sb.size(), 0);
    wait_fail(200, n);
    check("r4_end_fail_seen", fail_o, 1);
    check("r4_end_fail_timeout", fail_timeout_o, 1);
    tick(3);

    // Round 5: reset mid-round, then a fresh round
    start_round(8'b11_10_01_00);
    expect_echo(2'b00, 3'd1, 1'b0, 1'b0, 1'b0);
    expect_echo(2'b01, 3'd2, 1'b0, 1'b0, 1'b0);
    press(0); press(1);
    check("r5_step_before_reset", step_o, 2);
    reset_n = 1'b0;
    tick(1);
    check_reset_values("midreset");
    reset_n = 1'b1;
    tick(5);
    check("r5_no_verdict_busy", busy_o, 0);
    check("r5_no_verdict_fail", fail_o, 0);
    start_round(8'b00_00_00_11);
    check("r5_new_step", step_o, 0);
    check("r5_new_busy", busy_o, 1);
    expect_echo(2'b11, 3'd1, 1'b0, 1'b0, 1'b0);
    press(3);
    check("r5_sb_drained", sb.size(), 0);
    check("r5_step_after_press", step_o, 1);
    wait_fail(200, n);
    check("r5_end_fail_seen", fail_o, 1);
    check("r5_end_fail_timeout", fail_timeout_o, 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
